// File: rtl/irq_source_ctrl_if.sv
// Memory-mapped register bus for irq_source_ctrl: address, write strobe,
// write data and registered read data.
interface irq_source_ctrl_if;
    logic [31:0] data_address;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output data_address,
        output wr_en,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  data_address,
        input  wr_en,
        input  wr_data,
        output rd_data
    );
endinterface

// File: rtl/irq_source_ctrl.sv
// Interrupt source controller: rising-edge event capture, software trigger,
// W1C pending register, per-line enable (line 0 is an unmaskable NMI) and a
// periodic down-counter timer that raises line 15.
module irq_source_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    irq_source_ctrl_if.slave       bus,
    input  logic [15:0]            event_in,
    output logic [15:0]            irq_out,
    output logic                   timer_tick
);

    localparam logic [31:0] ADDR_PEND   = 32'hFFFF_FF20;
    localparam logic [31:0] ADDR_ENABLE = 32'hFFFF_FF24;
    localparam logic [31:0] ADDR_SWTRIG = 32'hFFFF_FF28;
    localparam logic [31:0] ADDR_RELOAD = 32'hFFFF_FF2C;
    localparam logic [31:0] ADDR_COUNT  = 32'hFFFF_FF30;

    logic [15:0] event_in_q;
    logic        armed_q;      // low until the first edge after reset
    logic [15:0] pending_q;
    logic [15:1] enable_q;
    logic [31:0] reload_q;
    logic [31:0] count_q;

    logic        wr_pend;
    logic        wr_enable;
    logic        wr_swtrig;
    logic        wr_reload;
    logic        expire;
    logic [15:0] event_vec;
    logic [15:0] set_vec;
    logic [15:0] clr_vec;
    logic [15:0] enable_full;
    logic [15:0] enable_next;
    logic [15:0] pending_next;
    logic [15:0] irq_next;
    logic [31:0] count_next;
    logic [31:0] rd_next;

    // Address decode, set/clear arbitration, timer next value and read mux.
    always_comb begin
        wr_pend     = bus.wr_en && (bus.data_address == ADDR_PEND);
        wr_enable   = bus.wr_en && (bus.data_address == ADDR_ENABLE);
        wr_swtrig   = bus.wr_en && (bus.data_address == ADDR_SWTRIG);
        wr_reload   = bus.wr_en && (bus.data_address == ADDR_RELOAD);

        expire      = (reload_q != 32'd0) && (count_q == 32'd1);

        // A line already high when reset releases is absorbed into event_in_q
        // on the first edge instead of being reported as an edge.
        event_vec   = event_in & ~event_in_q & {16{armed_q}};

        set_vec     = event_vec;
        if (wr_swtrig)
            set_vec = set_vec | bus.wr_data[15:0];
        if (expire)
            set_vec[15] = 1'b1;

        clr_vec     = 16'h0000;
        if (wr_pend)
            clr_vec = bus.wr_data[15:0];

        pending_next = (pending_q & ~clr_vec) | set_vec;

        enable_full = {enable_q, 1'b1};
        enable_next = enable_full;
        if (wr_enable)
            enable_next = {bus.wr_data[15:1], 1'b1};

        // New sets reach irq_out one edge after pending (two-cycle event
        // latency), while clears and enable changes take effect on the edge
        // of the write itself. A clear that loses to a set is no clear.
        irq_next    = pending_q & ~(clr_vec & ~set_vec) & enable_next;

        if (wr_reload)
            count_next = bus.wr_data;
        else if (reload_q == 32'd0)
            count_next = 32'd0;
        else if (expire)
            count_next = reload_q;
        else
            count_next = count_q - 32'd1;

        rd_next = 32'd0;
        case (bus.data_address)
            ADDR_PEND:   rd_next = {16'h0000, pending_q};
            ADDR_ENABLE: rd_next = {16'h0000, enable_full};
            ADDR_RELOAD: rd_next = reload_q;
            ADDR_COUNT:  rd_next = count_q;
            default:     rd_next = 32'd0;
        endcase
    end

    // Edge detector history and post-reset arming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_in_q <= 16'h0000;
            armed_q    <= 1'b0;
        end else begin
            event_in_q <= event_in;
            armed_q    <= 1'b1;
        end
    end

    // Pending, enable and registered interrupt lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 16'h0000;
            enable_q  <= 15'h0000;
            irq_out   <= 16'h0000;
        end else begin
            pending_q <= pending_next;
            enable_q  <= enable_next[15:1];
            irq_out   <= irq_next;
        end
    end

    // Periodic timer: RELOAD=0 parks the counter at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_q   <= 32'd0;
            count_q    <= 32'd0;
            timer_tick <= 1'b0;
        end else begin
            if (wr_reload)
                reload_q <= bus.wr_data;
            count_q    <= count_next;
            timer_tick <= expire;
        end
    end

    // Registered read data, sampled from pre-write register values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.rd_data <= 32'd0;
        else
            bus.rd_data <= rd_next;
    end

endmodule
